// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with pointer-addressed register file and local host port
// Optional SCL stretching after written data bytes: define I2C_TGT_STRETCH_EN.
module i2c_target_regfile #(
    parameter logic [6:0] ADDR  = 7'h39,
    parameter int         DEPTH = 16,
    parameter int         FILT  = 3
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_o,
    output logic                     scl_o,
    input  logic [$clog2(DEPTH)-1:0] loc_addr,
    input  logic                     loc_wr,
    input  logic [7:0]               loc_d,
    output logic [7:0]               loc_q,
    output logic                     wr_strobe,
    output logic [$clog2(DEPTH)-1:0] wr_index,
    output logic [7:0]               wr_data,
    output logic                     busy,
    input  logic                     wr_ready
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through synchroniser and filter.
    logic [1:0] sync1, sync2, filt, filt_d;
    logic [7:0] fcnt [2];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {sda_i, scl_i};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (fcnt[i] >= 8'(FILT - 1)) begin
                        filt[i] <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 8'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start, stop;
    assign scl_rise = filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] & filt_d[0];
    assign start    = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
    assign stop     = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];

    state_t          state;
    logic [7:0]      shreg;
    logic [3:0]      bitcnt;
    logic            rw, mack;
    logic [AW-1:0]   ptr, ptr_nxt;
    logic [7:0]      rf [DEPTH];

    assign ptr_nxt = ptr + 1'b1;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            sda_o     <= 1'b1;
            busy      <= 1'b0;
            ptr       <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            rw        <= 1'b0;
            mack      <= 1'b1;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            // Local write comes first so a same-cycle I2C write to that index overrides it.
            if (loc_wr) rf[loc_addr] <= loc_d;
            if (start) begin
                state  <= S_ADDR;
                bitcnt <= '0;
                busy   <= 1'b1;
                sda_o  <= 1'b1;
            end else if (stop) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                sda_o <= 1'b1;
            end else begin
                case (state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (scl_rise && bitcnt < 4'd8) begin
                            shreg  <= {shreg[6:0], filt[1]};
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            bitcnt <= '0;
                            if (state == S_ADDR) begin
                                if (shreg[7:1] == ADDR) begin
                                    sda_o <= 1'b0;
                                    rw    <= shreg[0];
                                    state <= S_ADDR_ACK;
                                end else begin
                                    state <= S_IGNORE;
                                end
                            end else if (state == S_PTR) begin
                                ptr   <= shreg[AW-1:0];
                                sda_o <= 1'b0;
                                state <= S_PTR_ACK;
                            end else begin
                                rf[ptr]   <= shreg;
                                wr_strobe <= 1'b1;
                                wr_index  <= ptr;
                                wr_data   <= shreg;
                                ptr       <= ptr_nxt;
                                sda_o     <= 1'b0;
                                state     <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        if (rw) begin
                            shreg <= rf[ptr];
                            sda_o <= rf[ptr][7];
                            state <= S_RDATA;
                        end else begin
                            sda_o <= 1'b1;
                            state <= S_PTR;
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        sda_o <= 1'b1;
                        state <= S_WDATA;
                    end
                    S_RDATA: begin
                        if (scl_rise && bitcnt < 4'd8) bitcnt <= bitcnt + 4'd1;
                        if (scl_fall) begin
                            if (bitcnt == 4'd8) begin
                                sda_o  <= 1'b1;
                                bitcnt <= '0;
                                state  <= S_RDATA_ACK;
                            end else begin
                                sda_o <= shreg[6];
                                shreg <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise) mack <= filt[1];
                        if (scl_fall) begin
                            if (!mack) begin
                                ptr   <= ptr_nxt;
                                shreg <= rf[ptr_nxt];
                                sda_o <= rf[ptr_nxt][7];
                                state <= S_RDATA;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end
                    end
                    default: sda_o <= 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) loc_q <= '0;
        else       loc_q <= rf[loc_addr];
    end

`ifdef I2C_TGT_STRETCH_EN
    logic scl_hold_n, stretch_set;
    assign stretch_set = (state == S_WDATA_ACK) && scl_fall && !start && !stop;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)                                            scl_hold_n <= 1'b1;
        else if (stop || state == S_IDLE || state == S_IGNORE) scl_hold_n <= 1'b1;
        else if (stretch_set)                                 scl_hold_n <= 1'b0;
        else if (wr_ready)                                    scl_hold_n <= 1'b1;
    end
    assign scl_o = scl_hold_n;
`else
    logic unused_wr_ready;
    assign unused_wr_ready = wr_ready;
    assign scl_o = 1'b1;
`endif
endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- Synthesizable, parametrised I2C target (slave) with an internal register file. Runs on sysclk and oversamples SCL/SDA.
- Successor to the capture-only I2C slave model used behind the cfide I2C bridge: adds address matching, a register pointer, reads, auto-increment and a local host port.
- Serves as the loopback target in bridge regression. Also usable on-chip, e.g. an RTC/config shadow.

Parameters:
- ADDR, 7'h39, 7-bit target address (0x72 write / 0x73 read).
- DEPTH, 16, number of 8-bit registers; power of 2, 2..256.
- FILT, 3, SCL/SDA glitch filter length in sysclk cycles; an input must be stable this many cycles to change state.

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- scl_i  in  1  SCL as seen on the wire
- sda_i  in  1  SDA as seen on the wire
- sda_o  out  1  open-drain SDA drive; 0 = pull low, 1 = release
- scl_o  out  1  open-drain SCL drive (stretch); 0 = hold low, 1 = release
- loc_addr  in  clog2(DEPTH)  local register index
- loc_wr  in  1  local write strobe
- loc_d  in  8  local write data
- loc_q  out  8  registered read of regfile[loc_addr]; 1-cycle latency
- wr_strobe  out  1  1-cycle pulse when an I2C data byte is written
- wr_index  out  clog2(DEPTH)  index of that byte
- wr_data  out  8  value of that byte
- busy  out  1  high from START to STOP
- wr_ready  in  1  local consumer ready; used only with the optional feature

Behaviour:
- Reset values: sda_o=1, scl_o=1, loc_q=0, wr_strobe=0, wr_index=0, wr_data=0, busy=0, pointer=0, regfile all 0, FSM=IDLE.
- Reset mid-transfer releases both lines immediately and returns the FSM to IDLE.
- Input path: 2-flop synchroniser, then FILT-cycle filter.
  - START = filtered SDA falls while SCL is high.
  - STOP = filtered SDA rises while SCL is high.
  - SDA is sampled on filtered SCL rise; sda_o changes only after SCL fall.
- START (including repeated START) from any state: bit counter cleared, busy=1, FSM=ADDR.
- STOP from any state: FSM=IDLE, busy=0.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits, MSB first.
  - On a match of [7:1]==ADDR: drive ACK (sda_o=0) for the 9th clock. R/W=0 goes to PTR; R/W=1 loads the shift register from regfile[pointer] and goes to RDATA.
  - On a mismatch: no ACK, FSM=IGNORE until the next START or STOP.
- PTR: the first byte after a write address sets pointer = byte mod DEPTH; ACK; then WDATA.
- WDATA: each byte is ACKed and written to regfile[pointer].
  - In the same cycle: wr_strobe=1 with wr_index=pointer and wr_data=byte.
  - pointer increments and wraps DEPTH-1 -> 0.
- RDATA: drive bit on SCL low; release SDA for the 9th clock and sample the master ACK.
  - ACK (SDA=0): pointer++ with wrap, reload, continue.
  - NACK: go to IGNORE (SDA released) until STOP or repeated START.
- The pointer persists across transactions. A write of only the pointer byte followed by a repeated START and read reads from that pointer.
- Local port: loc_wr writes regfile[loc_addr] on the clock edge.
  - If an I2C write hits the same index in the same cycle, the I2C write wins and wr_strobe still fires.
  - loc_q updates every cycle from loc_addr.
- While IDLE or IGNORE, sda_o=1 and scl_o=1 at all times.

Optional Feature:
- Macro I2C_TGT_STRETCH_EN.
  - Defined: after the ACK clock of each WDATA byte, the target holds scl_o=0 from SCL fall until wr_ready=1, then releases. STOP or reset also releases.
  - Not defined: scl_o is tied to 1 and wr_ready is ignored.

Test Plan:
- Write 0x72, ptr 0x05, data 0x1E,0xBB,0x27, STOP -> all ACKed; three wr_strobe pulses at index 5,6,7 with those values; loc_addr=7 gives loc_q=0x27 after 1 cycle; busy drops after STOP.
- Write 0x72, ptr 0x0F, data 0xAA,0x55 (DEPTH=16) -> regfile[15]=0xAA, regfile[0]=0x55 (wrap).
- Write 0x72, ptr 0x06, repeated START, 0x73, read 2 bytes ACK then NACK, STOP -> returns 0xBB,0x27; SDA released after NACK.
- Address 0x50 write with data -> no ACK on any clock; no wr_strobe; regfile unchanged.
- Local write regfile[3]=0x42 and I2C write to index 3 with 0x99 in the same cycle -> regfile[3]=0x99.
- With I2C_TGT_STRETCH_EN and wr_ready=0 for 200 cycles after a data ACK -> SCL held low 200 cycles, then released; next byte transfers correctly. Reset asserted mid-byte -> sda_o=scl_o=1 and FSM IDLE.
